// File: rtl/mem_monitor_if.sv
// Host-link, memory-port and CPU-control signals of the loader/monitor.
// master is the monitor side; slave is the link/memory/CPU side.
interface mem_monitor_if #(
  parameter int addr_width = 9
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            mem_data_out;
  logic [7:0]            mem_data_in;
  logic [addr_width-1:0] mem_raddr;
  logic [addr_width-1:0] mem_waddr;
  logic                  mem_write;
  logic                  mem_sel;
  logic                  cpu_reset;
  logic                  cpu_halt;
  logic [addr_width-1:0] cpu_start_address;
  logic                  cpu_halted;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_data_out, cpu_halted,
    output rx_ready, tx_data, tx_valid, mem_data_in, mem_raddr, mem_waddr,
           mem_write, mem_sel, cpu_reset, cpu_halt, cpu_start_address
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_data_out, cpu_halted,
    input  rx_ready, tx_data, tx_valid, mem_data_in, mem_raddr, mem_waddr,
           mem_write, mem_sel, cpu_reset, cpu_halt, cpu_start_address
  );
endinterface

// File: rtl/mem_monitor.sv
// Byte-stream loader/monitor: writes and reads CPU memory while the CPU is
// held in reset, and starts/stops the CPU on host command.
module mem_monitor #(
  parameter int addr_width = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_monitor_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_AH, S_AL, S_LEN, S_WDATA, S_WSET, S_WSTB,
    S_RADDR, S_RWAIT, S_RSAMP, S_TXW, S_REPLY, S_RUNRST, S_RUN
  } state_t;

  localparam logic [7:0] C_WRITE = 8'h57;
  localparam logic [7:0] C_READ  = 8'h52;
  localparam logic [7:0] C_EXEC  = 8'h58;
  localparam logic [7:0] C_STOP  = 8'h53;
  localparam logic [7:0] C_OK    = 8'h4B;
  localparam logic [7:0] C_HALT  = 8'h48;
  localparam logic [7:0] C_ERR   = 8'h3F;

  state_t                r_state, w_state_next;
  logic [7:0]            r_cmd, w_cmd_next;
  logic [7:0]            r_ah, w_ah_next;
  logic [addr_width-1:0] r_addr, w_addr_next;
  logic [8:0]            r_count, w_count_next;
  logic                  r_run_cnt, w_run_cnt_next;
  logic [7:0]            r_tx_data, w_tx_data_next;
  logic                  r_tx_valid, w_tx_valid_next;
  logic [7:0]            r_mem_data_in, w_mem_data_in_next;
  logic [addr_width-1:0] r_mem_raddr, w_mem_raddr_next;
  logic [addr_width-1:0] r_mem_waddr, w_mem_waddr_next;
  logic                  r_mem_write, w_mem_write_next;
  logic                  r_mem_sel, w_mem_sel_next;
  logic                  r_cpu_reset, w_cpu_reset_next;
  logic                  r_cpu_halt, w_cpu_halt_next;
  logic [addr_width-1:0] r_cpu_start, w_cpu_start_next;
  logic                  r_rx_ready, w_rx_ready_next;

  logic                  w_rx_fire;
  logic                  w_tx_fire;
  logic [addr_width-1:0] w_addr_in;

  assign w_rx_fire = bus.rx_valid & r_rx_ready;
  assign w_tx_fire = r_tx_valid & bus.tx_ready;
  assign w_addr_in = addr_width'({r_ah, bus.rx_data});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cmd         <= 8'h00;
      r_ah          <= 8'h00;
      r_addr        <= '0;
      r_count       <= 9'd0;
      r_run_cnt     <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_mem_data_in <= 8'h00;
      r_mem_raddr   <= '0;
      r_mem_waddr   <= '0;
      r_mem_write   <= 1'b0;
      r_mem_sel     <= 1'b1;
      r_cpu_reset   <= 1'b1;
      r_cpu_halt    <= 1'b0;
      r_cpu_start   <= '0;
      r_rx_ready    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cmd         <= w_cmd_next;
      r_ah          <= w_ah_next;
      r_addr        <= w_addr_next;
      r_count       <= w_count_next;
      r_run_cnt     <= w_run_cnt_next;
      r_tx_data     <= w_tx_data_next;
      r_tx_valid    <= w_tx_valid_next;
      r_mem_data_in <= w_mem_data_in_next;
      r_mem_raddr   <= w_mem_raddr_next;
      r_mem_waddr   <= w_mem_waddr_next;
      r_mem_write   <= w_mem_write_next;
      r_mem_sel     <= w_mem_sel_next;
      r_cpu_reset   <= w_cpu_reset_next;
      r_cpu_halt    <= w_cpu_halt_next;
      r_cpu_start   <= w_cpu_start_next;
      r_rx_ready    <= w_rx_ready_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cmd_next         = r_cmd;
    w_ah_next          = r_ah;
    w_addr_next        = r_addr;
    w_count_next       = r_count;
    w_run_cnt_next     = r_run_cnt;
    w_tx_data_next     = r_tx_data;
    w_tx_valid_next    = r_tx_valid;
    w_mem_data_in_next = r_mem_data_in;
    w_mem_raddr_next   = r_mem_raddr;
    w_mem_waddr_next   = r_mem_waddr;
    w_mem_write_next   = 1'b0;
    w_mem_sel_next     = r_mem_sel;
    w_cpu_reset_next   = r_cpu_reset;
    w_cpu_halt_next    = r_cpu_halt;
    w_cpu_start_next   = r_cpu_start;

    case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          w_cmd_next = bus.rx_data;
          if (bus.rx_data == C_WRITE || bus.rx_data == C_READ || bus.rx_data == C_EXEC) begin
            w_state_next = S_AH;
          end else begin
            w_tx_data_next  = C_ERR;
            w_tx_valid_next = 1'b1;
            w_state_next    = S_REPLY;
          end
        end
      end
      S_AH: begin
        if (w_rx_fire) begin
          w_ah_next    = bus.rx_data;
          w_state_next = S_AL;
        end
      end
      S_AL: begin
        if (w_rx_fire) begin
          w_addr_next = w_addr_in;
          if (r_cmd == C_EXEC) begin
            w_cpu_start_next = w_addr_in;
            w_run_cnt_next   = 1'b0;
            w_state_next     = S_RUNRST;
          end else begin
            w_state_next = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (w_rx_fire) begin
          // A zero length byte stands for a full 256-byte block.
          w_count_next = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          w_state_next = (r_cmd == C_WRITE) ? S_WDATA : S_RADDR;
        end
      end
      S_WDATA: begin
        if (w_rx_fire) begin
          w_mem_waddr_next   = r_addr;
          w_mem_data_in_next = bus.rx_data;
          w_addr_next        = r_addr + 1'b1;
          w_state_next       = S_WSET;
        end
      end
      S_WSET: begin
        w_mem_write_next = 1'b1;
        w_state_next     = S_WSTB;
      end
      S_WSTB: begin
        w_count_next = r_count - 9'd1;
        if (r_count == 9'd1) begin
          w_tx_data_next  = C_OK;
          w_tx_valid_next = 1'b1;
          w_state_next    = S_REPLY;
        end else begin
          w_state_next = S_WDATA;
        end
      end
      S_RADDR: begin
        w_mem_raddr_next = r_addr;
        w_addr_next      = r_addr + 1'b1;
        w_state_next     = S_RWAIT;
      end
      S_RWAIT: w_state_next = S_RSAMP;
      S_RSAMP: begin
        // Memory data for the address issued two edges ago is valid now.
        w_tx_data_next  = bus.mem_data_out;
        w_tx_valid_next = 1'b1;
        w_state_next    = S_TXW;
      end
      S_TXW: begin
        if (w_tx_fire) begin
          w_tx_valid_next = 1'b0;
          w_count_next    = r_count - 9'd1;
          w_state_next    = (r_count == 9'd1) ? S_IDLE : S_RADDR;
        end
      end
      S_REPLY: begin
        if (w_tx_fire) begin
          w_tx_valid_next = 1'b0;
          w_state_next    = S_IDLE;
        end
      end
      S_RUNRST: begin
        if (r_run_cnt) begin
          w_cpu_reset_next = 1'b0;
          w_mem_sel_next   = 1'b0;
          w_state_next     = S_RUN;
        end else begin
          w_run_cnt_next = 1'b1;
        end
      end
      S_RUN: begin
        // Halted takes priority; a stop byte arriving in the same cycle is dropped.
        if (bus.cpu_halted) begin
          w_cpu_reset_next = 1'b1;
          w_cpu_halt_next  = 1'b0;
          w_mem_sel_next   = 1'b1;
          w_tx_data_next   = C_HALT;
          w_tx_valid_next  = 1'b1;
          w_state_next     = S_REPLY;
        end else if (w_rx_fire && bus.rx_data == C_STOP) begin
          w_cpu_halt_next = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_rx_ready_next = (w_state_next inside {S_IDLE, S_AH, S_AL, S_LEN, S_WDATA, S_RUN});
  end

  assign bus.rx_ready          = r_rx_ready;
  assign bus.tx_data           = r_tx_data;
  assign bus.tx_valid          = r_tx_valid;
  assign bus.mem_data_in       = r_mem_data_in;
  assign bus.mem_raddr         = r_mem_raddr;
  assign bus.mem_waddr         = r_mem_waddr;
  assign bus.mem_write         = r_mem_write;
  assign bus.mem_sel           = r_mem_sel;
  assign bus.cpu_reset         = r_cpu_reset;
  assign bus.cpu_halt          = r_cpu_halt;
  assign bus.cpu_start_address = r_cpu_start;
endmodule

// File: tb/tb_mem_monitor.sv
// Directed bench for mem_monitor with a registered-read memory and a CPU stub
// that dumps zeros to memory 2..65 before raising halted.
module tb_mem_monitor;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_monitor_if #(.addr_width(9)) bus();
  mem_monitor #(.addr_width(9)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mem [0:511];
  logic       loop_prog = 1'b0;
  logic       halted    = 1'b0;
  logic       cpu_dump  = 1'b0;
  int         cyc       = 0;
  assign bus.cpu_halted = halted;

  always @(posedge clk) begin
    bus.mem_data_out <= mem[bus.mem_raddr];
    if (bus.mem_sel && bus.mem_write) mem[bus.mem_waddr] <= bus.mem_data_in;
    else if (!bus.mem_sel && cpu_dump) for (int i = 2; i < 66; i++) mem[i] <= 8'h00;
  end

  // CPU stub: straight-line program halts after 20 cycles, looping one on cpu_halt.
  always @(posedge clk) begin
    cpu_dump <= 1'b0;
    if (bus.cpu_reset) begin
      cyc    <= 0;
      halted <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (!halted && !cpu_dump && (loop_prog ? bus.cpu_halt : (cyc == 20))) cpu_dump <= 1'b1;
      if (cpu_dump) halted <= 1'b1;
    end
  end

  logic [8:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int         long_pulses = 0;
  logic       prev_wr = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_write) begin
      wr_addr.push_back(bus.mem_waddr);
      wr_data.push_back(bus.mem_data_in);
    end
    if (bus.mem_write && prev_wr) long_pulses <= long_pulses + 1;
    prev_wr <= bus.mem_write;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: byte %h not accepted, want accepted", b);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.tx_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_vec++; n_bad++;
      $display("FAIL recv_timeout: tx_valid=0, want 1");
      b = 8'h00;
    end else begin
      b = bus.tx_data;
      bus.tx_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.rx_ready, bus.tx_valid, bus.mem_write, bus.cpu_halt, bus.cpu_reset, bus.mem_sel} !== 6'b000011) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 000011", {bus.rx_ready, bus.tx_valid, bus.mem_write, bus.cpu_halt, bus.cpu_reset, bus.mem_sel});
    end
    n_vec++;
    if ({bus.tx_data, bus.mem_data_in, bus.mem_raddr, bus.mem_waddr, bus.cpu_start_address} !== 43'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {bus.tx_data, bus.mem_data_in, bus.mem_raddr, bus.mem_waddr, bus.cpu_start_address});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.rx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_rx_ready: got %b want 1", bus.rx_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] b;
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h20); send_byte(8'h02); send_byte(8'hAA);
    n_vec++;
    if ({bus.mem_waddr, bus.mem_data_in} !== {9'h020, 8'hAA}) begin
      n_bad++;
      $display("FAIL abort_setup: got %h want %h", {bus.mem_waddr, bus.mem_data_in}, {9'h020, 8'hAA});
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.rx_ready, bus.tx_valid, bus.mem_write, bus.cpu_halt, bus.cpu_reset, bus.mem_sel} !== 6'b000011) begin
      n_bad++;
      $display("FAIL abort_ctl: got %b want 000011", {bus.rx_ready, bus.tx_valid, bus.mem_write, bus.cpu_halt, bus.cpu_reset, bus.mem_sel});
    end
    n_vec++;
    if ({bus.tx_data, bus.mem_data_in, bus.mem_raddr, bus.mem_waddr, bus.cpu_start_address} !== 43'd0) begin
      n_bad++;
      $display("FAIL abort_data: got %h want 0", {bus.tx_data, bus.mem_data_in, bus.mem_raddr, bus.mem_waddr, bus.cpu_start_address});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    n_vec++;
    if (wr_addr.size() !== 0) begin
      n_bad++;
      $display("FAIL abort_no_write: got %0d writes want 0", wr_addr.size());
    end
    send_byte(8'h11);
    recv_byte(b);
    n_vec++;
    if (b !== 8'h3F) begin
      n_bad++;
      $display("FAIL bad_cmd_reply: got %h want 3f", b);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] b;
    logic [7:0] exp_d [3];
    int cnt;
    int lp;
    bit seen;
    exp_d[0] = 8'hAA; exp_d[1] = 8'hBB; exp_d[2] = 8'hCC;
    wr_addr.delete(); wr_data.delete();
    lp = long_pulses;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
    for (int i = 0; i < 3; i++) send_byte(exp_d[i]);
    cnt = 0;
    while (!bus.tx_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    n_vec++;
    if (cnt !== 2) begin
      n_bad++;
      $display("FAIL k_latency: got %0d cycles want 2", cnt);
    end
    recv_byte(b);
    n_vec++;
    if (b !== 8'h4B) begin
      n_bad++;
      $display("FAIL write_reply: got %h want 4b", b);
    end
    n_vec++;
    if (wr_addr.size() !== 3) begin
      n_bad++;
      $display("FAIL write_count: got %0d want 3", wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if ({wr_addr[i], wr_data[i]} !== {9'h010 + 9'(i), exp_d[i]}) begin
          n_bad++;
          $display("FAIL write_%0d: got %h want %h", i, {wr_addr[i], wr_data[i]}, {9'h010 + 9'(i), exp_d[i]});
        end
      end
    end
    n_vec++;
    if (long_pulses !== lp) begin
      n_bad++;
      $display("FAIL strobe_width: got %0d long pulses want 0", long_pulses - lp);
    end
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
    cnt = 0;
    while (!bus.tx_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    n_vec++;
    if (cnt !== 3) begin
      n_bad++;
      $display("FAIL read_latency: got %0d cycles want 3", cnt);
    end
    for (int i = 0; i < 3; i++) begin
      recv_byte(b);
      n_vec++;
      if (b !== exp_d[i]) begin
        n_bad++;
        $display("FAIL read_%0d: got %h want %h", i, b, exp_d[i]);
      end
    end
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (bus.tx_valid) seen = 1'b1; end
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL no_trailer: got tx_valid=1 want 0");
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b;
    logic [7:0] d0;
    logic [8:0] a0;
    int cnt;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h11); send_byte(8'h02);
    cnt = 0;
    while (!bus.tx_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    d0 = bus.tx_data;
    a0 = bus.mem_raddr;
    n_vec++;
    if ({d0, a0} !== {8'hBB, 9'h011}) begin
      n_bad++;
      $display("FAIL bp_first: got %h want %h", {d0, a0}, {8'hBB, 9'h011});
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if ({bus.tx_valid, bus.tx_data, bus.mem_raddr} !== {1'b1, d0, a0}) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got %h want %h", i, {bus.tx_valid, bus.tx_data, bus.mem_raddr}, {1'b1, d0, a0});
      end
    end
    recv_byte(b);
    recv_byte(b);
    n_vec++;
    if (b !== 8'hCC) begin
      n_bad++;
      $display("FAIL bp_second: got %h want cc", b);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h57); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'hA5);
    recv_byte(b);
    n_vec++;
    if (b !== 8'h4B) begin
      n_bad++;
      $display("FAIL wrap_reply: got %h want 4b", b);
    end
    n_vec++;
    if (wr_addr.size() !== 256) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d want 256", wr_addr.size());
    end else begin
      n_vec++;
      if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[255], wr_data[255]}
          !== {9'h1FF, 8'hA5, 9'h000, 8'hA4, 9'h0FE, 8'h5A}) begin
        n_bad++;
        $display("FAIL wrap_addrs: got %h/%h %h/%h %h/%h want 1ff/a5 000/a4 0fe/5a",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[255], wr_data[255]);
      end
    end
    send_byte(8'h52); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h02);
    recv_byte(b);
    n_vec++;
    if (b !== 8'hA5) begin
      n_bad++;
      $display("FAIL wrap_read0: got %h want a5", b);
    end
    recv_byte(b);
    n_vec++;
    if (b !== 8'hA4) begin
      n_bad++;
      $display("FAIL wrap_read1: got %h want a4", b);
    end
  endtask

  task automatic test_run();
    logic [7:0] b;
    loop_prog = 1'b0;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h04); send_byte(8'h02);
    send_byte(8'hFF); send_byte(8'hFF);
    recv_byte(b);
    send_byte(8'h58); send_byte(8'h00); send_byte(8'h04);
    n_vec++;
    if ({bus.cpu_start_address, bus.cpu_reset, bus.mem_sel} !== {9'h004, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL run_start: got %h want %h", {bus.cpu_start_address, bus.cpu_reset, bus.mem_sel}, {9'h004, 1'b1, 1'b1});
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({bus.cpu_reset, bus.mem_sel} !== 2'b11) begin
      n_bad++;
      $display("FAIL run_rst2: got %b want 11", {bus.cpu_reset, bus.mem_sel});
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({bus.cpu_reset, bus.mem_sel} !== 2'b00) begin
      n_bad++;
      $display("FAIL run_release: got %b want 00", {bus.cpu_reset, bus.mem_sel});
    end
    recv_byte(b);
    n_vec++;
    if ({b, bus.mem_sel, bus.cpu_reset, bus.cpu_halt} !== {8'h48, 3'b110}) begin
      n_bad++;
      $display("FAIL run_halted: got %h want %h", {b, bus.mem_sel, bus.cpu_reset, bus.cpu_halt}, {8'h48, 3'b110});
    end
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h02); send_byte(8'h04);
    for (int i = 0; i < 4; i++) begin
      recv_byte(b);
      n_vec++;
      if (b !== 8'h00) begin
        n_bad++;
        $display("FAIL dump_r0_%0d: got %h want 00", i, b);
      end
    end
  endtask

  task automatic test_stop();
    logic [7:0] b;
    loop_prog = 1'b1;
    send_byte(8'h58); send_byte(8'h00); send_byte(8'h04);
    repeat (4) @(posedge clk);
    #1;
    send_byte(8'h41);
    n_vec++;
    if ({bus.cpu_halt, bus.mem_sel, bus.cpu_reset} !== 3'b000) begin
      n_bad++;
      $display("FAIL stop_other_byte: got %b want 000", {bus.cpu_halt, bus.mem_sel, bus.cpu_reset});
    end
    send_byte(8'h53);
    n_vec++;
    if (bus.cpu_halt !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_halt: got %b want 1", bus.cpu_halt);
    end
    recv_byte(b);
    n_vec++;
    if ({b, bus.mem_sel, bus.cpu_reset, bus.cpu_halt} !== {8'h48, 3'b110}) begin
      n_bad++;
      $display("FAIL stop_halted: got %h want %h", {b, bus.mem_sel, bus.cpu_reset, bus.cpu_halt}, {8'h48, 3'b110});
    end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    test_reset();
    test_reset_abort();
    test_write_read();
    test_backpressure();
    test_wrap();
    test_run();
    test_stop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
